// File: rtl/pcs_chmodel_pkg.sv
// Shared definitions for the PCS channel-model blocks: rf mode codes,
// sync-header values and the error-injector FSM state encoding.
package pcs_chmodel_pkg;

    localparam logic [1:0] MODE_ALIN = 2'd0;
    localparam logic [1:0] MODE_CTRL = 2'd1;
    localparam logic [1:0] MODE_DATA = 2'd2;
    localparam logic [1:0] MODE_ALL  = 2'd3;

    localparam logic [1:0] SH_CTRL = 2'b10;
    localparam logic [1:0] SH_DATA = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } brk_state_t;

    // True while a burst/gap pattern is being played out.
    function automatic logic is_active_state(input brk_state_t st);
        return (st == ST_BURST) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/breaker_err_ctrl.sv
// Burst/period/repeat sequencer for the multilane payload breaker.
// Holds the shadow timing configuration and walks IDLE/BURST/GAP/DONE,
// advancing only on valid cycles.
module breaker_err_ctrl
    import pcs_chmodel_pkg::*;
#(
    parameter int NB_BURST_CNT  = 10,
    parameter int NB_PERIOD_CNT = 10,
    parameter int NB_REPEAT_CNT = 10
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    input  logic                     i_update,
    input  logic [NB_BURST_CNT-1:0]  i_burst,
    input  logic [NB_PERIOD_CNT-1:0] i_period,
    input  logic [NB_REPEAT_CNT-1:0] i_repeat,
    output logic                     o_burst_on,
    output logic                     o_active
);

    localparam logic [NB_BURST_CNT-1:0]  BURST_ONE  = NB_BURST_CNT'(1);
    localparam logic [NB_PERIOD_CNT-1:0] PERIOD_ONE = NB_PERIOD_CNT'(1);
    localparam logic [NB_REPEAT_CNT-1:0] REPEAT_ONE = NB_REPEAT_CNT'(1);

    brk_state_t               state_q,      state_d;
    logic [NB_BURST_CNT-1:0]  burst_cnt_q,  burst_cnt_d;
    logic [NB_PERIOD_CNT-1:0] period_cnt_q, period_cnt_d;
    logic [NB_REPEAT_CNT-1:0] repeat_cnt_q, repeat_cnt_d;
    logic [NB_BURST_CNT-1:0]  burst_sh_q,   burst_sh_d;
    logic [NB_PERIOD_CNT-1:0] period_sh_q,  period_sh_d;
    logic [NB_REPEAT_CNT-1:0] repeat_sh_q,  repeat_sh_d;
    logic                     active_q,     active_d;

    // Next-state and counter update; an update restarts the pattern, period end wins over burst end.
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        period_cnt_d = period_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
        burst_sh_d   = burst_sh_q;
        period_sh_d  = period_sh_q;
        repeat_sh_d  = repeat_sh_q;
        if (i_update) begin
            burst_sh_d   = i_burst;
            period_sh_d  = i_period;
            repeat_sh_d  = i_repeat;
            burst_cnt_d  = i_burst;
            period_cnt_d = i_period;
            repeat_cnt_d = i_repeat;
            if (i_period == '0) begin
                state_d = ST_IDLE;
            end else if (i_burst != '0) begin
                state_d = ST_BURST;
            end else begin
                state_d = ST_GAP;
            end
        end else if (i_valid && is_active_state(state_q)) begin
            period_cnt_d = period_cnt_q - PERIOD_ONE;
            if (state_q == ST_BURST) begin
                burst_cnt_d = burst_cnt_q - BURST_ONE;
            end else begin
                burst_cnt_d = burst_cnt_q;
            end
            if (period_cnt_q == PERIOD_ONE) begin
                // Last block of this period: start the next one or stop.
                if ((repeat_sh_q == '0) || (repeat_cnt_q > REPEAT_ONE)) begin
                    if (repeat_sh_q != '0) begin
                        repeat_cnt_d = repeat_cnt_q - REPEAT_ONE;
                    end else begin
                        repeat_cnt_d = repeat_cnt_q;
                    end
                    period_cnt_d = period_sh_q;
                    burst_cnt_d  = burst_sh_q;
                    state_d      = (burst_sh_q != '0) ? ST_BURST : ST_GAP;
                end else begin
                    repeat_cnt_d = '0;
                    state_d      = ST_DONE;
                end
            end else if ((state_q == ST_BURST) && (burst_cnt_q == BURST_ONE)) begin
                state_d = ST_GAP;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
        active_d = is_active_state(state_d);
    end

    // State, counter and shadow registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= '0;
            period_cnt_q <= '0;
            repeat_cnt_q <= '0;
            burst_sh_q   <= '0;
            period_sh_q  <= '0;
            repeat_sh_q  <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            period_cnt_q <= period_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
            burst_sh_q   <= burst_sh_d;
            period_sh_q  <= period_sh_d;
            repeat_sh_q  <= repeat_sh_d;
            active_q     <= active_d;
        end
    end

    assign o_burst_on = (state_q == ST_BURST);
    assign o_active   = active_q;

endmodule

// File: rtl/multilane_payload_breaker.sv
// Multilane 66b payload error injector for the channel model.
// Optional macro PAYLOAD_BREAKER_SH_ERR_EN: corrupted lanes also get their
// sync header XORed with the shadowed sh mask.
module multilane_payload_breaker
    import pcs_chmodel_pkg::*;
#(
    parameter int N_LANES        = 4,
    parameter int NB_CODED_BLOCK = 66,
    parameter int NB_SH          = 2,
    parameter int NB_PAYLOAD     = NB_CODED_BLOCK - NB_SH,
    parameter int MAX_ERR_BURST  = 1024,
    parameter int MAX_ERR_PERIOD = 1024,
    parameter int MAX_ERR_REPEAT = 1024,
    parameter int NB_BURST_CNT   = $clog2(MAX_ERR_BURST),
    parameter int NB_PERIOD_CNT  = $clog2(MAX_ERR_PERIOD),
    parameter int NB_REPEAT_CNT  = $clog2(MAX_ERR_REPEAT),
    parameter int NB_ERR_CNT     = 32
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic                              i_valid,
    input  logic [N_LANES*NB_CODED_BLOCK-1:0] i_data,
    input  logic [N_LANES-1:0]                i_aligner_tag,
    input  logic [1:0]                        i_rf_mode,
    input  logic [N_LANES-1:0]                i_rf_lane_enable,
    input  logic [NB_PAYLOAD-1:0]             i_rf_error_mask,
    input  logic [NB_SH-1:0]                  i_rf_sh_mask,
    input  logic [NB_BURST_CNT-1:0]           i_rf_error_burst,
    input  logic [NB_PERIOD_CNT-1:0]          i_rf_error_period,
    input  logic [NB_REPEAT_CNT-1:0]          i_rf_error_repeat,
    input  logic                              i_rf_update,
    input  logic                              i_rf_clear_cnt,
    output logic [N_LANES*NB_CODED_BLOCK-1:0] o_data,
    output logic                              o_valid,
    output logic [N_LANES-1:0]                o_err_tag,
    output logic [NB_ERR_CNT-1:0]             o_err_count,
    output logic                              o_active
);

    logic [NB_PAYLOAD-1:0]             mask_q,      mask_d;
    logic [1:0]                        mode_q,      mode_d;
    logic [N_LANES-1:0]                lane_en_q,   lane_en_d;
    logic [N_LANES*NB_CODED_BLOCK-1:0] data_q,      data_d;
    logic                              valid_q;
    logic [N_LANES-1:0]                err_tag_q,   err_tag_d;
    logic [NB_ERR_CNT-1:0]             err_count_q, err_count_d;
    logic [NB_ERR_CNT-1:0]             tag_sum_s;
    logic [NB_ERR_CNT:0]               cnt_sum_s;
    logic                              burst_on_s;
    logic                              hit_s;

`ifdef PAYLOAD_BREAKER_SH_ERR_EN
    logic [NB_SH-1:0] sh_mask_q;

    // Shadow sync-header mask, captured only on update.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sh_mask_q <= '0;
        end else if (i_rf_update) begin
            sh_mask_q <= i_rf_sh_mask;
        end else begin
            sh_mask_q <= sh_mask_q;
        end
    end
`else
    logic [NB_SH-1:0] unused_sh_mask_s;
    assign unused_sh_mask_s = i_rf_sh_mask;
`endif

    breaker_err_ctrl #(
        .NB_BURST_CNT  (NB_BURST_CNT),
        .NB_PERIOD_CNT (NB_PERIOD_CNT),
        .NB_REPEAT_CNT (NB_REPEAT_CNT)
    ) u_err_ctrl (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .i_update   (i_rf_update),
        .i_burst    (i_rf_error_burst),
        .i_period   (i_rf_error_period),
        .i_repeat   (i_rf_error_repeat),
        .o_burst_on (burst_on_s),
        .o_active   (o_active)
    );

    // Shadow corruption config: live rf values only matter in the update cycle.
    always_comb begin
        mask_d    = mask_q;
        mode_d    = mode_q;
        lane_en_d = lane_en_q;
        if (i_rf_update) begin
            mask_d    = i_rf_error_mask;
            mode_d    = i_rf_mode;
            lane_en_d = i_rf_lane_enable;
        end else begin
            mask_d    = mask_q;
            mode_d    = mode_q;
            lane_en_d = lane_en_q;
        end
    end

    // The update-cycle block is always clean; an all-zero mask breaks nothing.
    assign hit_s = burst_on_s & ~i_rf_update & i_valid & (|mask_q);

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic [NB_CODED_BLOCK-1:0] blk_in_s;
        logic [NB_CODED_BLOCK-1:0] blk_out_s;
        logic [NB_SH-1:0]          sh_s;
        logic                      match_s;

        assign blk_in_s = i_data[k*NB_CODED_BLOCK +: NB_CODED_BLOCK];
        assign sh_s     = blk_in_s[NB_CODED_BLOCK-1 -: NB_SH];

        // Block-type filter on the incoming (pre-corruption) header.
        always_comb begin
            match_s = 1'b0;
            case (mode_q)
                MODE_ALIN: match_s = i_aligner_tag[k];
                MODE_CTRL: match_s = (sh_s == SH_CTRL);
                MODE_DATA: match_s = (sh_s == SH_DATA);
                MODE_ALL:  match_s = 1'b1;
                default:   match_s = 1'b1;
            endcase
        end

        assign err_tag_d[k] = hit_s & lane_en_q[k] & match_s;

        // Apply the error mask to a selected lane block.
        always_comb begin
            blk_out_s = blk_in_s;
            if (err_tag_d[k]) begin
                blk_out_s[NB_PAYLOAD-1:0] = blk_in_s[NB_PAYLOAD-1:0] ^ mask_q;
`ifdef PAYLOAD_BREAKER_SH_ERR_EN
                blk_out_s[NB_CODED_BLOCK-1 -: NB_SH] = sh_s ^ sh_mask_q;
`endif
            end else begin
                blk_out_s = blk_in_s;
            end
        end

        assign data_d[k*NB_CODED_BLOCK +: NB_CODED_BLOCK] = blk_out_s;
    end

    // Broken lane-block counter: saturating add, clear has priority.
    always_comb begin
        tag_sum_s = '0;
        for (int k = 0; k < N_LANES; k++) begin
            tag_sum_s = tag_sum_s + {{(NB_ERR_CNT-1){1'b0}}, err_tag_d[k]};
        end
        cnt_sum_s = {1'b0, err_count_q} + {1'b0, tag_sum_s};
        if (i_rf_clear_cnt) begin
            err_count_d = '0;
        end else if (cnt_sum_s[NB_ERR_CNT]) begin
            err_count_d = '1;
        end else begin
            err_count_d = cnt_sum_s[NB_ERR_CNT-1:0];
        end
    end

    // Output and shadow-config registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_tag_q   <= '0;
            err_count_q <= '0;
            mask_q      <= '0;
            mode_q      <= 2'd0;
            lane_en_q   <= '0;
        end else begin
            data_q      <= data_d;
            valid_q     <= i_valid;
            err_tag_q   <= err_tag_d;
            err_count_q <= err_count_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            lane_en_q   <= lane_en_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_err_tag   = err_tag_q;
    assign o_err_count = err_count_q;

endmodule

// File: tb/tb_multilane_payload_breaker.sv
// Self-checking bench for multilane_payload_breaker with a block-index
// reference model: the j-th valid block after an update is broken when
// j/period < repeat (or repeat==0) and j%period < burst.
module tb_multilane_payload_breaker;

    localparam int N  = 4;
    localparam int CB = 66;
    localparam int PL = 64;
    localparam int DW = N * CB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [DW-1:0] data;
    logic [N-1:0]  atag;
    logic [1:0]    mode;
    logic [N-1:0]  lane_en;
    logic [PL-1:0] mask;
    logic [1:0]    shm;
    logic [9:0]    burst, period, rf_repeat;
    logic          update, clr;

    logic [DW-1:0] o_data;
    logic          o_valid;
    logic [N-1:0]  o_err_tag;
    logic [31:0]   o_err_count;
    logic          o_active;

    logic [301:0]  obs_all;
    assign obs_all = {o_valid, o_active, o_err_count, o_err_tag, o_data};

    int checks = 0;
    int errors = 0;

    // reference model state
    bit            m_armed;
    int            m_j, m_b, m_p, m_r;
    logic [PL-1:0] m_mask;
    logic [1:0]    m_mode, m_shm;
    logic [N-1:0]  m_lane;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  exp_tag;
    logic [31:0]   exp_cnt;
    logic          exp_valid, exp_active;
    logic [301:0]  exp_all;

    multilane_payload_breaker dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_valid           (valid),
        .i_data            (data),
        .i_aligner_tag     (atag),
        .i_rf_mode         (mode),
        .i_rf_lane_enable  (lane_en),
        .i_rf_error_mask   (mask),
        .i_rf_sh_mask      (shm),
        .i_rf_error_burst  (burst),
        .i_rf_error_period (period),
        .i_rf_error_repeat (rf_repeat),
        .i_rf_update       (update),
        .i_rf_clear_cnt    (clr),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .o_err_tag         (o_err_tag),
        .o_err_count       (o_err_count),
        .o_active          (o_active)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd_blocks();
        logic [DW-1:0] v;
        logic [31:0]   t;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        t = $urandom;
        v[DW-1 -: 8] = t[7:0];
        return v;
    endfunction

    function automatic bit in_run(int j);
        if (!m_armed || m_p == 0) return 1'b0;
        return (m_r == 0) || ((j / m_p) < m_r);
    endfunction

    function automatic bit lane_match(int k);
        logic [1:0] sh;
        sh = data[k*CB+PL +: 2];
        case (m_mode)
            2'd0:    return atag[k];
            2'd1:    return sh == 2'b10;
            2'd2:    return sh == 2'b01;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model_reset();
        m_armed = 1'b0; m_j = 0; m_b = 0; m_p = 0; m_r = 0;
        m_mask = '0; m_mode = 2'd0; m_shm = 2'd0; m_lane = '0;
        exp_cnt = '0;
    endfunction

    // Predict this cycle's outputs from the model, advance the model, clock once.
    task automatic step();
        logic [DW-1:0] d;
        logic [N-1:0]  t;
        bit            hit;
        longint        s;
        d = data; t = '0; hit = 1'b0;
        if (!update && valid && in_run(m_j) && (m_mask != '0))
            hit = ((m_j % m_p) < m_b);
        for (int k = 0; k < N; k++) begin
            if (hit && m_lane[k] && lane_match(k)) begin
                t[k] = 1'b1;
                d[k*CB +: PL] = d[k*CB +: PL] ^ m_mask;
`ifdef PAYLOAD_BREAKER_SH_ERR_EN
                d[k*CB+PL +: 2] = d[k*CB+PL +: 2] ^ m_shm;
`endif
            end
        end
        s = longint'(exp_cnt) + longint'($countones(t));
        if (clr) exp_cnt = '0;
        else if (s > 64'hFFFF_FFFF) exp_cnt = '1;
        else exp_cnt = s[31:0];
        if (update) begin
            m_armed = 1'b1; m_j = 0;
            m_b = int'(burst); m_p = int'(period); m_r = int'(rf_repeat);
            m_mask = mask; m_mode = mode; m_lane = lane_en; m_shm = shm;
        end else if (valid && in_run(m_j)) begin
            m_j++;
        end
        exp_active = in_run(m_j);
        exp_valid  = valid;
        exp_data   = d;
        exp_tag    = t;
        exp_all    = {exp_valid, exp_active, exp_cnt, exp_tag, exp_data};
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [1:0] md, input logic [N-1:0] le, input logic [PL-1:0] mk,
                             input int b, input int p, input int r);
        mode = md; lane_en = le; mask = mk;
        burst = 10'(b); period = 10'(p); rf_repeat = 10'(r);
        update = 1'b1; clr = 1'b1; valid = 1'b1; data = rnd_blocks();
        step();
        update = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; data = '0; atag = '0; mode = 2'd0; lane_en = '0;
        mask = '0; shm = 2'd0; burst = '0; period = '0; rf_repeat = '0; update = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs_all !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", obs_all);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // live rf changes without update must have no effect
        mode = 2'd3; lane_en = '1; mask = '1; burst = 10'd5; period = 10'd5;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; data = rnd_blocks();
            step();
            checks++;
            if (obs_all !== exp_all || o_err_tag !== 4'h0) begin
                errors++; $display("FAIL reset_passthru blk %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_plan_burst();
        bit listed;
        configure(2'd3, 4'hF, 64'h1, 2, 5, 3);
        checks++;
        if (o_err_tag !== 4'h0 || o_active !== 1'b1) begin
            errors++; $display("FAIL plan_update_cycle: got tag %h act %b want 0 1", o_err_tag, o_active);
        end
        for (int i = 0; i < 20; i++) begin
            data = rnd_blocks();
            step();
            listed = (i == 0) || (i == 1) || (i == 5) || (i == 6) || (i == 10) || (i == 11);
            checks++;
            if (o_err_tag !== (listed ? 4'hF : 4'h0) || obs_all !== exp_all) begin
                errors++; $display("FAIL plan_blk %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
        checks++;
        if (o_err_count !== 32'd24 || o_active !== 1'b0) begin
            errors++; $display("FAIL plan_total: got cnt %0d act %b want 24 0", o_err_count, o_active);
        end
    endtask

    task automatic test_ctrl_lane1();
        configure(2'd1, 4'b0010, {$urandom, $urandom} | 64'h1, 4, 4, 0);
        for (int i = 0; i < 24; i++) begin
            data = rnd_blocks();
            data[CB+PL +: 2] = (i % 2 == 0) ? 2'b10 : 2'b01;
            step();
            checks++;
            if (o_err_tag !== ((i % 2 == 0) ? 4'b0010 : 4'b0000) || obs_all !== exp_all) begin
                errors++; $display("FAIL ctrl_blk %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
        checks++;
        if (o_active !== 1'b1 || o_err_count !== 32'd12) begin
            errors++; $display("FAIL ctrl_infinite: got act %b cnt %0d want 1 12", o_active, o_err_count);
        end
    endtask

    task automatic test_valid_gaps();
        configure(2'd3, 4'hF, {$urandom, $urandom} | 64'h80, 3, 6, 0);
        for (int i = 0; i < 40; i++) begin
            valid = (i < 3) ? 1'b1 : (i < 6) ? 1'b0 : 1'(($urandom % 2));
            data = rnd_blocks();
            step();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL gaps_cyc %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
        valid = 1'b1;
    endtask

    task automatic test_update_mid_gap();
        logic [N-1:0] want [5];
        want = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
        configure(2'd3, 4'hF, {$urandom, $urandom} | 64'h2, 1, 2, 0);
        for (int i = 0; i < 5; i++) begin
            data = rnd_blocks();
            update = (i == 1);
            step();
            checks++;
            if (o_err_tag !== want[i] || obs_all !== exp_all) begin
                errors++; $display("FAIL upd_gap blk %0d: got tag %h want %h", i, o_err_tag, want[i]);
            end
        end
        update = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] prev;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) configure(2'd3, 4'hF, 64'hFFFF, 3, 0, 0);
            else        configure(2'd3, 4'hF, 64'h0, 2, 4, 0);
            for (int i = 0; i < 10; i++) begin
                valid = 1'($urandom % 2); data = rnd_blocks(); prev = data;
                step();
                checks++;
                if (o_data !== prev || o_err_tag !== 4'h0 || o_err_count !== 32'd0 || obs_all !== exp_all) begin
                    errors++; $display("FAIL passthru c%0d blk %0d: got %h want %h", c, i, o_data, prev);
                end
            end
        end
        valid = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        configure(2'd3, 4'hF, {$urandom, $urandom} | 64'h4, 8, 10, 0);
        for (int i = 0; i < 3; i++) begin
            data = rnd_blocks();
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_all !== '0) begin
            errors++; $display("FAIL rst_mid_async: got %h want 0", obs_all);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = rnd_blocks();
            step();
            checks++;
            if (obs_all !== exp_all || o_err_tag !== 4'h0 || o_active !== 1'b0) begin
                errors++; $display("FAIL rst_mid_after blk %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
    endtask

`ifdef PAYLOAD_BREAKER_SH_ERR_EN
    task automatic test_sh_err();
        shm = 2'b11;
        configure(2'd2, 4'hF, 64'h1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            data = rnd_blocks();
            for (int k = 0; k < N; k++) data[k*CB+PL +: 2] = 2'b01;
            step();
            checks++;
            if (o_data[PL +: 2] !== 2'b10 || obs_all !== exp_all) begin
                errors++; $display("FAIL sh_err blk %0d: got sh %b want 10", i, o_data[PL +: 2]);
            end
        end
        shm = 2'b00;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            update = ($urandom % 40 == 0);
            if (update) begin
                mode = 2'($urandom); lane_en = 4'($urandom); shm = 2'($urandom);
                mask = ($urandom % 8 == 0) ? 64'h0 : {$urandom, $urandom};
                burst = 10'($urandom_range(0, 8)); period = 10'($urandom_range(0, 7));
                rf_repeat = 10'($urandom_range(0, 3));
            end
            clr = ($urandom % 50 == 0);
            valid = ($urandom % 4 != 0);
            atag = 4'($urandom);
            data = rnd_blocks();
            step();
            checks++;
            if (obs_all !== exp_all) begin
                errors++; $display("FAIL random_cyc %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
        update = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plan_burst();
        test_ctrl_lane1();
        test_valid_gaps();
        test_update_mid_gap();
        test_passthrough();
`ifdef PAYLOAD_BREAKER_SH_ERR_EN
        test_sh_err();
`endif
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
